stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, giving the number of requesting valid/ready sources.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data width per source.
REQ-003 The block SHALL have input aclk, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have input aresetn, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input s_valid, NUM_SRC bits: per-source valid.
REQ-006 The block SHALL have input s_data, NUM_SRC*WIDTH bits: source i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have input s_last, NUM_SRC bits: per-source end-of-packet marker.
REQ-008 The block SHALL have output s_ready, NUM_SRC bits: per-source ready.
REQ-009 The block SHALL have output m_valid, 1 bit: output beat valid.
REQ-010 The block SHALL have output m_data, WIDTH bits: output beat data.
REQ-011 The block SHALL have output m_last, 1 bit: output end-of-packet marker.
REQ-012 The block SHALL have output m_src, clog2(NUM_SRC) bits: index of the source that produced the beat.
REQ-013 The block SHALL have input m_ready, 1 bit: downstream ready.

Function
REQ-014 The FSM SHALL have two states: IDLE (no grant) and LOCK (grant held by one source).
REQ-015 In IDLE with any s_valid high, the arbiter SHALL select the first asserted source scanning upward from ptr, modulo NUM_SRC, register it in grant, and move to LOCK.
REQ-016 In IDLE, all s_ready bits SHALL be 0, giving a 1-cycle arbitration bubble per packet.
REQ-017 In LOCK, s_ready[grant] SHALL equal (!m_valid || m_ready), and every other s_ready bit SHALL be 0.
REQ-018 A beat SHALL be accepted when s_valid[grant] && s_ready[grant].
REQ-019 On acceptance, m_data, m_last and m_src SHALL load from source grant on the same edge, and m_valid SHALL be set, giving 1-cycle latency.
REQ-020 m_valid SHALL clear when m_ready is high and no beat is accepted in the same cycle.
REQ-021 m_data, m_last and m_src SHALL be held stable while m_valid && !m_ready.
REQ-022 Back-to-back beats with m_ready held high SHALL sustain one beat per cycle.
REQ-023 Acceptance of a beat with s_last=1 SHALL return the FSM to IDLE and set ptr to (grant+1) mod NUM_SRC, with wrap-around from NUM_SRC-1 to 0.
REQ-024 A grant SHALL NOT be revoked mid-packet; s_valid on other sources SHALL be ignored while in LOCK.
REQ-025 A granted source dropping s_valid mid-packet SHALL keep the lock, with no beat transferred.
REQ-026 A single-beat packet (s_last=1 on the first beat) SHALL complete LOCK in one acceptance cycle.
REQ-027 If exactly one source requests, that source SHALL be granted regardless of ptr.

Reset
REQ-028 While aresetn is low, the block SHALL hold: state=IDLE, ptr=0, grant=0, m_valid=0, m_data=0, m_last=0, m_src=0, s_ready=0.
REQ-029 Reset asserted mid-packet SHALL discard the in-flight beat and lock immediately (asynchronously).
REQ-030 After reset deassertion, the first arbitration SHALL occur on the first rising edge with any s_valid high.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE, LOCK) and the default NUM_SRC and WIDTH values.
REQ-032 The round-robin priority selector SHALL be a separate combinational sub-module, rr_select: inputs req and ptr; outputs gnt_idx and any_req.

Verification
REQ-033 Reset: aresetn=0 for 20 ns with s_valid=4'b1111 -> all outputs 0, s_ready=0; first grant goes to src0.
REQ-034 Single source: src2 sends a 3-beat packet 0xAADD1234, 0x3333_1234, 0x7777_CCCC (last on third), m_ready=1 -> one bubble cycle, then 3 consecutive m_valid beats with m_src=2, m_last only on 0x7777_CCCC; ptr=3 afterwards.
REQ-035 Fairness: all four sources continuously send 1-beat packets -> m_src sequence 0,1,2,3,0 with one bubble between packets.
REQ-036 Backpressure: m_ready=0 for 3 cycles mid-packet carrying 0x1111_2222 -> m_data held at 0x1111_2222, s_ready[grant]=0, no beat lost or duplicated after m_ready returns to 1.
REQ-037 Lock: src1 in LOCK drops s_valid for 2 cycles while src0 requests -> src0 gets no s_ready; src1's packet completes; src0 is granted next.
REQ-038 Mid-packet reset: aresetn pulsed low during the second beat of a src3 packet -> m_valid=0 immediately; after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin stream arbiter.
// State encoding, default geometry and a width helper used across the slice.
package stream_rr_arbiter_pkg;

    localparam int DEF_NUM_SRC = 4;
    localparam int DEF_WIDTH   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Index width for a source count; kept at least 1 so a single-source build still has a port.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of per-source valid/ready inputs and the merged output stream.
// slave = arbiter side, master = the environment feeding and draining it.
interface stream_rr_arbiter_if
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int WIDTH   = DEF_WIDTH
);
    localparam int SRC_W = src_w(NUM_SRC);

    logic [NUM_SRC-1:0]       s_valid;
    logic [NUM_SRC*WIDTH-1:0] s_data;
    logic [NUM_SRC-1:0]       s_last;
    logic [NUM_SRC-1:0]       s_ready;

    logic                     m_valid;
    logic [WIDTH-1:0]         m_data;
    logic                     m_last;
    logic [SRC_W-1:0]         m_src;
    logic                     m_ready;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_src
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_src
    );

endinterface

// File: rtl/stream_rr_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted request scanning upward from ptr.
module rr_select
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int SRC_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any_req
);

    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            // First hit wins; later hits further from ptr are ignored.
            if (!any_req && req[idx[SRC_W-1:0]]) begin
                gnt_idx = idx[SRC_W-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC valid/ready streams into one.
// A grant is held from the first beat to the s_last beat; one idle cycle re-arbitrates.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                aclk,
    input  logic                aresetn,
    stream_rr_arbiter_if.slave  bus
);

    localparam int SRC_W = src_w(NUM_SRC);

    arb_state_e         state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic               m_valid_q, m_valid_d;
    logic [WIDTH-1:0]   m_data_q, m_data_d;
    logic               m_last_q, m_last_d;
    logic [SRC_W-1:0]   m_src_q, m_src_d;

    logic [SRC_W-1:0]   sel_idx;
    logic               any_req;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               out_free;
    logic               accept;
    logic [NUM_SRC-1:0] s_ready;

    rr_select #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_select (
        .req     (bus.s_valid),
        .ptr     (ptr_q),
        .gnt_idx (sel_idx),
        .any_req (any_req)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == SRC_W'(i)) sel_data = bus.s_data[i*WIDTH +: WIDTH];
        end
    end

    assign sel_valid = bus.s_valid[grant_q];
    assign sel_last  = bus.s_last[grant_q];

    // Output register can take a beat when empty or when its current beat leaves this cycle.
    assign out_free = !m_valid_q || bus.m_ready;
    assign accept   = (state_q == LOCK) && sel_valid && out_free;

    always_comb begin
        s_ready = '0;
        if (state_q == LOCK) s_ready[grant_q] = out_free;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                    if (grant_q == SRC_W'(NUM_SRC - 1)) ptr_d = '0;
                    else                                ptr_d = grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_src_d   = m_src_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = sel_data;
            m_last_d  = sel_last;
            m_src_d   = grant_q;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_src_q   <= m_src_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_src   = m_src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench: per-source beat queues feed the arbiter, a negedge monitor scores the output.
module tb_stream_rr_arbiter;
    import stream_rr_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    stream_rr_arbiter_if #(.NUM_SRC(N), .WIDTH(W)) bus ();

    stream_rr_arbiter #(.NUM_SRC(N), .WIDTH(W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    beat_t      srcq [N][16];
    int         wr [N];
    int         rd [N];
    logic [N-1:0] hold = '0;
    beat_t      exp_q [$];
    int         beat_cyc [$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    function void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function void refresh();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i] && !hold[i]) begin
                bus.s_valid[i]         = 1'b1;
                bus.s_data[i*W +: W]   = srcq[i][rd[i]].data;
                bus.s_last[i]          = srcq[i][rd[i]].last;
            end else begin
                bus.s_valid[i]         = 1'b0;
                bus.s_data[i*W +: W]   = '0;
                bus.s_last[i]          = 1'b0;
            end
        end
    endfunction

    // Queue a beat on a source and record the beat the output must eventually show.
    function void send(input int s, input logic [31:0] d, input logic l, input bit expect_out);
        beat_t b;
        b.src  = s[1:0];
        b.last = l;
        b.data = d;
        srcq[s][wr[s]] = b;
        wr[s]++;
        if (expect_out) exp_q.push_back(b);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_data(input logic [31:0] d, input string name);
        int n = 0;
        while (!(bus.m_valid === 1'b1 && bus.m_data === d) && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(n < 20), 64'd1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Source driver: pops a beat after each handshake, re-presents heads after the test thread acts.
    initial begin
        logic [N-1:0] fire;
        fire = '0;
        #1 refresh();
        forever begin
            @(negedge aclk);
            fire = bus.s_valid & bus.s_ready;
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) if (fire[i]) rd[i]++;
            refresh();
            #2;
            refresh();
        end
    end

    // Output monitor
    initial begin
        beat_t e;
        forever begin
            @(negedge aclk);
            cyc++;
            if (aresetn && bus.m_valid && bus.m_ready) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {29'd0, bus.m_src, bus.m_last, bus.m_data}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {29'd0, bus.m_src, bus.m_last, bus.m_data},
                                  {29'd0, e.src, e.last, e.data});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int c0;
        bus.m_ready = 1'b1;

        // Reset with all sources requesting; then fairness over five single-beat packets.
        send(0, 32'hF000_0000, 1'b1, 1'b1);
        send(1, 32'hF000_0001, 1'b1, 1'b1);
        send(2, 32'hF000_0002, 1'b1, 1'b1);
        send(3, 32'hF000_0003, 1'b1, 1'b1);
        send(0, 32'hF000_0004, 1'b1, 1'b1);
        #12;
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_data",  64'(bus.m_data),  64'd0);
        check("rst_m_last",  64'(bus.m_last),  64'd0);
        check("rst_m_src",   64'(bus.m_src),   64'd0);
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        #10 aresetn = 1'b1;
        wait_drain("fair_drain");
        check("fair_count", 64'(beat_cyc.size()), 64'd5);
        for (int i = 1; i < beat_cyc.size(); i++)
            check("fair_gap", 64'(beat_cyc[i] - beat_cyc[i-1]), 64'd2);

        // Single source, three beats, m_ready high throughout.
        tick();
        beat_cyc.delete();
        c0 = cyc;
        send(2, 32'hAADD_1234, 1'b0, 1'b1);
        send(2, 32'h3333_1234, 1'b0, 1'b1);
        send(2, 32'h7777_CCCC, 1'b1, 1'b1);
        wait_drain("single_drain");
        check("single_count", 64'(beat_cyc.size()), 64'd3);
        check("single_first", 64'(beat_cyc[0] - c0), 64'd3);
        check("single_gap1",  64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
        check("single_gap2",  64'(beat_cyc[2] - beat_cyc[1]), 64'd1);

        // ptr should now be 3: src3 beats src1.
        tick();
        send(1, 32'h6000_0001, 1'b1, 1'b0);
        send(3, 32'h6000_0003, 1'b1, 1'b1);
        exp_q.push_back('{src: 2'd1, last: 1'b1, data: 32'h6000_0001});
        wait_drain("ptr3_drain");

        // Backpressure on the middle beat.
        tick();
        send(0, 32'hB000_0000, 1'b0, 1'b1);
        send(0, 32'h1111_2222, 1'b0, 1'b1);
        send(0, 32'hB000_0002, 1'b1, 1'b1);
        wait_data(32'h1111_2222, "bp_seen");
        bus.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid",   64'(bus.m_valid), 64'd1);
            check("bp_data",    64'(bus.m_data),  64'h1111_2222);
            check("bp_s_ready", 64'(bus.s_ready), 64'd0);
        end
        bus.m_ready = 1'b1;
        wait_drain("bp_drain");

        // Lock: src1 stalls mid-packet while src0 waits.
        tick();
        send(1, 32'hC100_0000, 1'b0, 1'b1);
        send(1, 32'hC100_0001, 1'b0, 1'b1);
        send(1, 32'hC100_0002, 1'b1, 1'b1);
        send(0, 32'hC000_0000, 1'b1, 1'b1);
        wait_data(32'hC100_0000, "lock_seen");
        hold[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("lock_s_ready", 64'(bus.s_ready), 64'b0010);
            check("lock_m_valid", 64'(bus.m_valid), 64'd0);
        end
        hold[1] = 1'b0;
        wait_drain("lock_drain");

        // Reset in the middle of a src3 packet.
        tick();
        send(3, 32'hD000_0000, 1'b0, 1'b1);
        send(3, 32'hD000_0001, 1'b0, 1'b0);
        send(3, 32'hD000_0002, 1'b0, 1'b0);
        send(3, 32'hD000_0003, 1'b1, 1'b0);
        wait_data(32'hD000_0001, "mrst_seen");
        aresetn = 1'b0;
        wr[3] = rd[3];
        #1;
        check("mrst_m_valid", 64'(bus.m_valid), 64'd0);
        check("mrst_m_data",  64'(bus.m_data),  64'd0);
        check("mrst_s_ready", 64'(bus.s_ready), 64'd0);
        tick();
        aresetn = 1'b1;
        beat_cyc.delete();
        c0 = cyc;
        send(0, 32'hE000_0000, 1'b1, 1'b1);
        send(3, 32'hE000_0003, 1'b1, 1'b1);
        wait_drain("mrst_drain");
        check("mrst_first", 64'(beat_cyc[0] - c0), 64'd3);

        repeat (3) tick();
        check("end_idle", 64'(bus.m_valid), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
